// File: rtl/tdc_decoder_if.sv
// Handshake bundle between the TDC delay-line capture and the decoder.
// Master drives samples and the result ready; slave returns window results.
interface tdc_decoder_if #(
    parameter int N_DELAY = 32,
    parameter int CW      = $clog2(N_DELAY + 1)
);
    logic               enable;
    logic [N_DELAY-1:0] time_count;
    logic               tc_valid;
    logic               out_ready;
    logic               out_valid;
    logic [CW-1:0]      avg_out;
    logic [CW-1:0]      min_out;
    logic [CW-1:0]      max_out;
    logic               bubble_err;
    logic               dropped;

    modport master (
        output enable, time_count, tc_valid, out_ready,
        input  out_valid, avg_out, min_out, max_out, bubble_err, dropped
    );

    modport slave (
        input  enable, time_count, tc_valid, out_ready,
        output out_valid, avg_out, min_out, max_out, bubble_err, dropped
    );
endinterface

// File: rtl/tdc_decoder.sv
// Thermometer-code TDC decoder: popcount per sample, then average/min/max
// over windows of 2^LOG2_SAMPLES samples with a valid/ready result port.
module tdc_decoder #(
    parameter int N_DELAY      = 32,
    parameter int LOG2_SAMPLES = 4
) (
    input  logic           clk,
    input  logic           rst,
    tdc_decoder_if.slave   bus
);
    localparam int CW = $clog2(N_DELAY + 1);
    localparam int AW = CW + LOG2_SAMPLES;
    localparam int S  = 1 << LOG2_SAMPLES;

    localparam logic [LOG2_SAMPLES:0] LAST    = (LOG2_SAMPLES + 1)'(S - 1);
    localparam logic [LOG2_SAMPLES:0] CNT_ONE = (LOG2_SAMPLES + 1)'(1);
    localparam logic [N_DELAY-1:0]    TC_ONE  = {{(N_DELAY - 1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]         MIN_INIT = CW'(N_DELAY);

    typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DONE} state_t;

    state_t                state_q;
    logic [LOG2_SAMPLES:0] cnt_q;
    logic [AW-1:0]         acc_q;
    logic [CW-1:0]         min_q;
    logic [CW-1:0]         max_q;
    logic                  s1_valid_q;
    logic [CW-1:0]         s1_cnt_q;
    logic                  out_valid_q;
    logic [CW-1:0]         avg_q;
    logic [CW-1:0]         min_out_q;
    logic [CW-1:0]         max_out_q;
    logic                  bubble_q;
    logic                  dropped_q;

    logic [CW-1:0] dec_d;
    logic          therm_ok;
    logic          accept;
    logic          busy;
    logic [AW-1:0] acc_d;
    logic [CW-1:0] min_d;
    logic [CW-1:0] max_d;
    logic [CW-1:0] avg_d;

    always_comb begin
        dec_d = '0;
        for (int i = 0; i < N_DELAY; i++) begin
            dec_d = dec_d + CW'(bus.time_count[i]);
        end
    end

    assign therm_ok = ((bus.time_count & (bus.time_count + TC_ONE)) == '0);
    assign accept   = (state_q == ACCUM) && bus.tc_valid;
    assign busy     = (state_q == FLUSH) || (state_q == DONE);

    // Stage-2 next values; in FLUSH they already fold in the last sample.
    assign acc_d = acc_q + AW'(s1_cnt_q);
    assign min_d = (s1_cnt_q < min_q) ? s1_cnt_q : min_q;
    assign max_d = (s1_cnt_q > max_q) ? s1_cnt_q : max_q;
    assign avg_d = CW'(acc_d >> LOG2_SAMPLES);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            min_q       <= '0;
            max_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_cnt_q    <= '0;
            out_valid_q <= 1'b0;
            avg_q       <= '0;
            min_out_q   <= '0;
            max_out_q   <= '0;
            bubble_q    <= 1'b0;
            dropped_q   <= 1'b0;
        end else if (!bus.enable) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_cnt_q    <= '0;
            out_valid_q <= 1'b0;
            bubble_q    <= 1'b0;
            dropped_q   <= 1'b0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_cnt_q <= dec_d;
            end
            if (s1_valid_q) begin
                acc_q <= acc_d;
                min_q <= min_d;
                max_q <= max_d;
            end
            if (accept && !therm_ok) begin
                bubble_q <= 1'b1;
            end
            if (busy && bus.tc_valid) begin
                dropped_q <= 1'b1;
            end

            unique case (state_q)
                IDLE: begin
                    state_q <= ACCUM;
                    cnt_q   <= '0;
                    acc_q   <= '0;
                    min_q   <= MIN_INIT;
                    max_q   <= '0;
                end
                ACCUM: begin
                    if (accept) begin
                        cnt_q <= cnt_q + CNT_ONE;
                        if (cnt_q == LAST) begin
                            state_q <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    state_q     <= DONE;
                    avg_q       <= avg_d;
                    min_out_q   <= min_d;
                    max_out_q   <= max_d;
                    out_valid_q <= 1'b1;
                end
                DONE: begin
                    if (out_valid_q && bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ACCUM;
                        cnt_q       <= '0;
                        acc_q       <= '0;
                        min_q       <= MIN_INIT;
                        max_q       <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.avg_out    = avg_q;
    assign bus.min_out    = min_out_q;
    assign bus.max_out    = max_out_q;
    assign bus.bubble_err = bubble_q;
    assign bus.dropped    = dropped_q;
endmodule
